// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Single-cycle logic/arith ops plus iterative shift-add multiply.
// Define SEQ_ALU_DIV_EN to build the restoring divider; without it DIV decodes as an undefined op.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       ALUConf,
  input  logic             Sign,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             DivZero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_MULT = 5'b01000;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_SRA  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b11001;
  localparam logic [4:0] OP_ANDN = 5'b11111;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b01001;
`endif

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t               state, state_nxt;
  logic [SHW:0]         cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb_mag;
  logic                 neg_lo;

  logic [SHW-1:0]       shamt;
  logic                 slt;
  logic                 start_div;
  logic                 iter_op;
  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_res, fix_hi;
  logic                 fix_dz;

`ifdef SEQ_ALU_DIV_EN
  logic                 op_div;
  logic                 neg_hi;
  logic                 dz_pend;
  logic [WIDTH:0]       div_shift, div_diff;

  assign start_div = (ALUConf == OP_DIV);
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opb_mag};
`else
  assign start_div = 1'b0;
`endif

  assign shamt   = In1[SHW-1:0];
  assign slt     = Sign ? ($signed(In1) < $signed(In2)) : (In1 < In2);
  assign iter_op = (ALUConf == OP_MULT) || start_div;
  assign a_mag   = (Sign && In1[WIDTH-1]) ? ('0 - In1) : In1;
  assign b_mag   = (Sign && In2[WIDTH-1]) ? ('0 - In2) : In2;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_comb begin
    alu_res = '0;
    case (ALUConf)
      OP_ADD:  alu_res = In1 + In2;
      OP_OR:   alu_res = In1 | In2;
      OP_AND:  alu_res = In1 & In2;
      OP_SUB:  alu_res = In1 - In2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_res = ~(In1 | In2);
      OP_XOR:  alu_res = In1 ^ In2;
      OP_SRL:  alu_res = In2 >> shamt;
      OP_SRA:  alu_res = $signed(In2) >>> shamt;
      OP_SLL:  alu_res = In2 << shamt;
      OP_ANDN: alu_res = In1 & ~In2;
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_mag} : '0);
    acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    if (op_div) begin
      acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_comb begin
    prod_fix = neg_lo ? ('0 - acc) : acc;
    fix_res  = prod_fix[WIDTH-1:0];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_dz   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    // a zero divisor leaves |In1| as remainder, so the dividend-sign fixup restores In1 exactly
    if (op_div) begin
      fix_res = dz_pend ? '1 : (neg_lo ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0]);
      fix_hi  = neg_hi ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      fix_dz  = dz_pend;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = iter_op ? ITER : DONE;
      ITER:    if (cnt == CNT_ONE) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      opb_mag <= '0;
      neg_lo  <= 1'b0;
      Result  <= '0;
      Hi      <= '0;
      Zero    <= 1'b1;
      DivZero <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      op_div  <= 1'b0;
      neg_hi  <= 1'b0;
      dz_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && iter_op) begin
            cnt     <= CNT_INIT;
            acc     <= {{WIDTH{1'b0}}, a_mag};
            opb_mag <= b_mag;
            neg_lo  <= Sign & (In1[WIDTH-1] ^ In2[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
            op_div  <= start_div;
            neg_hi  <= start_div & Sign & In1[WIDTH-1];
            dz_pend <= start_div && (In2 == '0);
`endif
          end else if (start) begin
            Result  <= alu_res;
            Hi      <= '0;
            Zero    <= (alu_res == '0);
            DivZero <= 1'b0;
          end
        end
        ITER: begin
          acc <= acc_step;
          cnt <= cnt - CNT_ONE;
        end
        FIX: begin
          Result  <= fix_res;
          Hi      <= fix_hi;
          Zero    <= (fix_res == '0);
          DivZero <= fix_dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven and scoreboard-checked bench for seq_alu at WIDTH=32.
// Expectations follow SEQ_ALU_DIV_EN the same way the design build does.
module tb_seq_alu;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_MULT = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_SRA  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b11001;
  localparam logic [4:0] OP_ANDN = 5'b11111;
  localparam logic [4:0] OP_UNDEF = 5'b00011;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  conf;
    logic        sign;
    logic [31:0] in1, in2, res, hi;
    logic        dz;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res, hi;
    logic        zero, dz;
    int          lat;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [4:0]       ALUConf;
  logic             Sign;
  logic [WIDTH-1:0] In1, In2;
  logic             busy, done;
  logic [WIDTH-1:0] Result, Hi;
  logic             Zero, DivZero;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALUConf(ALUConf), .Sign(Sign),
    .In1(In1), .In2(In2), .busy(busy), .done(done), .Result(Result), .Hi(Hi),
    .Zero(Zero), .DivZero(DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input logic [4:0] c, input logic s,
                                  input logic [31:0] a, b, r, h, input logic dz);
    vec_t v;
    v.name = n; v.conf = c; v.sign = s; v.in1 = a; v.in2 = b; v.res = r; v.hi = h; v.dz = dz;
    vecs.push_back(v);
  endfunction

  // Behavioural reference built on the simulator's own arithmetic operators
  function automatic void model(input logic [4:0] c, input logic s, input logic [31:0] a, b,
                                output logic [31:0] r, output logic [31:0] h, output logic dz);
    logic [63:0] p;
    r = '0; h = '0; dz = 1'b0;
    case (c)
      OP_ADD:  r = a + b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = (s ? ($signed(a) < $signed(b)) : (a < b)) ? 32'd1 : 32'd0;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = b >> a[4:0];
      OP_SRA:  r = $signed(b) >>> a[4:0];
      OP_SLL:  r = b << a[4:0];
      OP_ANDN: r = a & ~b;
      OP_MULT: begin
        if (s) p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        else   p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        h = p[63:32];
      end
      OP_DIV: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            r = 32'hFFFFFFFF; h = a; dz = 1'b1;
          end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = a; h = 32'd0;
          end else if (s) begin
            r = $signed(a) / $signed(b);
            h = $signed(a) % $signed(b);
          end else begin
            r = a / b;
            h = a % b;
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Drives one op, scrambles inputs after capture, then waits (bounded) for done
  task automatic apply_stimulus(input string name, input logic [4:0] c, input logic s,
                                input logic [31:0] a, b, r, h, input logic dz, input bit hold);
    exp_t e;
    int   lat;
    e.name = name; e.res = r; e.hi = h; e.zero = (r == 32'd0); e.dz = dz;
    e.lat  = (c == OP_MULT || (DIV_EN && c == OP_DIV)) ? WIDTH + 1 : 0;
    exp_q.push_back(e);
    @(negedge clk);
    ALUConf = c; Sign = s; In1 = a; In2 = b; start = 1'b1;
    @(posedge clk); #1;
    check_output({name, " busy"}, 64'(busy), 64'd1);
    if (!hold) start = 1'b0;
    ALUConf = 5'($urandom); Sign = 1'($urandom); In1 = $urandom; In2 = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check_output({e.name, " latency"}, 64'(lat), 64'(e.lat));
    check_output({e.name, " Result"}, 64'(Result), 64'(e.res));
    check_output({e.name, " Hi"}, 64'(Hi), 64'(e.hi));
    check_output({e.name, " Zero"}, 64'(Zero), 64'(e.zero));
    check_output({e.name, " DivZero"}, 64'(DivZero), 64'(e.dz));
    @(posedge clk); #1;
    check_output({e.name, " done_pulse"}, 64'({done, busy}), 64'd0);
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] r, h, a, b;
    logic        dz, s, saw_done;
    logic [4:0]  c;
    logic [4:0]  codes [14];

    codes = '{OP_ADD, OP_OR, OP_AND, OP_SUB, OP_SLT, OP_NOR, OP_XOR,
              OP_SRL, OP_SRA, OP_SLL, OP_ANDN, OP_MULT, OP_DIV, 5'b10101};

    reset_n = 1'b0; start = 1'b0; ALUConf = '0; Sign = 1'b0; In1 = '0; In2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst busy/done", 64'({busy, done}), 64'd0);
    check_output("rst Result", 64'(Result), 64'd0);
    check_output("rst Hi", 64'(Hi), 64'd0);
    check_output("rst Zero/DivZero", 64'({Zero, DivZero}), 64'b10);
    @(negedge clk);
    reset_n = 1'b1;

    add_vec("add_wrap", OP_ADD, 0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0);
    add_vec("slt_s", OP_SLT, 1, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0);
    add_vec("slt_u", OP_SLT, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 0);
    add_vec("sra", OP_SRA, 0, 32'd4, 32'h80000000, 32'hF8000000, 0, 0);
    add_vec("srl", OP_SRL, 0, 32'd4, 32'h80000000, 32'h08000000, 0, 0);
    add_vec("sll_mask", OP_SLL, 0, 32'h21, 32'd1, 32'd2, 0, 0);
    add_vec("sub_zero", OP_SUB, 0, 32'd5, 32'd5, 32'd0, 0, 0);
    add_vec("or", OP_OR, 0, 32'hF0, 32'h0F, 32'hFF, 0, 0);
    add_vec("and", OP_AND, 0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
    add_vec("nor", OP_NOR, 0, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0);
    add_vec("xor", OP_XOR, 0, 32'hA5, 32'hFF, 32'h5A, 0, 0);
    add_vec("andn", OP_ANDN, 0, 32'hFF, 32'h0F, 32'hF0, 0, 0);
    add_vec("undef", OP_UNDEF, 0, 32'h1234, 32'h5678, 32'd0, 0, 0);
    add_vec("mult_s", OP_MULT, 1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF, 0);
    add_vec("mult_u", OP_MULT, 0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'h00000002, 0);
    add_vec("mult_mn", OP_MULT, 1, 32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 0);
`ifdef SEQ_ALU_DIV_EN
    add_vec("div_s", OP_DIV, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    add_vec("div_s2", OP_DIV, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
    add_vec("div_mn", OP_DIV, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
    add_vec("div_u", OP_DIV, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    add_vec("div_zero", OP_DIV, 0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1);
    add_vec("add_clr_dz", OP_ADD, 0, 32'd1, 32'd1, 32'd2, 0, 0);
`else
    add_vec("div_undef", OP_DIV, 0, 32'h1234, 32'd0, 32'd0, 32'd0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].name, vecs[i].conf, vecs[i].sign, vecs[i].in1, vecs[i].in2,
                     vecs[i].res, vecs[i].hi, vecs[i].dz, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      c = codes[$urandom_range(0, 13)];
      s = 1'($urandom);
      a = $urandom;
      b = $urandom;
      if (c == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
      else if (c == OP_DIV) b = b >> 16;
      model(c, s, a, b, r, h, dz);
      apply_stimulus($sformatf("rand%0d", i), c, s, a, b, r, h, dz, 1'b0);
    end

    // start held high through ITER and DONE must neither restart nor disturb the op
    model(OP_MULT, 1, 32'hFFFFFFF9, 32'd6, r, h, dz);
    apply_stimulus("hold_mult", OP_MULT, 1, 32'hFFFFFFF9, 32'd6, r, h, dz, 1'b1);
    apply_stimulus("hold_xor", OP_XOR, 0, 32'h0F0F, 32'h00FF, 32'h0FF0, 32'd0, 0, 1'b1);

    apply_stimulus("mult_pre", OP_MULT, 0, 32'h12345, 32'h10000, 32'h23450000, 32'd1, 0, 1'b0);

    // Abort: start MULT at k, stray start at k+5, reset (with start) sampled at k+10
    @(negedge clk);
    ALUConf = OP_MULT; Sign = 1'b0; In1 = 32'd5; In2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start   = (i == 5 || i == 10);
      reset_n = (i != 10);
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    start = 1'b0;
    check_output("abort busy/done", 64'({busy, done}), 64'd0);
    check_output("abort Result", 64'(Result), 64'd0);
    check_output("abort Hi", 64'(Hi), 64'd0);
    check_output("abort Zero/DivZero", 64'({Zero, DivZero}), 64'b10);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check_output("abort no_done", 64'(saw_done), 64'd0);
    apply_stimulus("post_abort", OP_ADD, 0, 32'd3, 32'd4, 32'd7, 32'd0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
